// File: rtl/chan_mux_rr.sv
// N-channel registered stream mux with a source-channel tag on the output.
// Define MUX_RR_EN for round-robin arbitration; otherwise i_sel picks the channel.
module chan_mux_rr #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8,
   parameter int SELW  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NCH-1:0]        i_valid,
   input  logic [NCH*WIDTH-1:0]  i_data,
   output logic [NCH-1:0]        o_ready,
   input  logic [SELW-1:0]       i_sel,
   output logic                  o_valid,
   output logic [WIDTH-1:0]      o_data,
   output logic [SELW-1:0]       o_chan,
   input  logic                  i_ready
);

   localparam int unsigned NCHU = NCH;

   logic            ld;
   logic            gv;
   logic            xfer;
   logic [SELW-1:0] g;
   logic [WIDTH-1:0] g_data;

   assign ld = ~o_valid | i_ready;

`ifdef MUX_RR_EN
   logic [SELW-1:0] ptr;
   logic            unused_sel;
   int              idx;

   assign unused_sel = ^i_sel;
   assign gv = |i_valid;

   // Descending scan: the nearest valid channel after ptr is assigned last.
   always_comb begin
      g   = '0;
      idx = 0;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NCH;
         if (i_valid[idx]) g = SELW'(idx);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     ptr <= SELW'(NCH - 1);
      else if (xfer) ptr <= g;
   end
`else
   assign g  = i_sel;
   assign gv = 32'(i_sel) < NCHU;
`endif

   assign xfer   = ld & gv & i_valid[g];
   assign g_data = i_data[int'(g)*WIDTH +: WIDTH];

   always_comb begin
      o_ready = '0;
      if (ld && gv && !i_rst) o_ready[g] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_chan  <= '0;
      end else if (xfer) begin
         o_valid <= 1'b1;
         o_data  <= g_data;
         o_chan  <= g;
      end else if (ld) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised N-channel, W-bit registered stream multiplexer. It is the successor to the combinational 4:1 bit mux. Each input channel presents data through a valid/ready handshake. One beat per cycle is selected and moved into a single output register, tagged with its source channel index. Selection is either an external select (i_sel) or a compile-time round-robin arbiter. The block sits between multiple producer channels and a single shared consumer (serialiser, bus, or logger).

## Interface
- NCH, 4: number of input channels, 2..16.
- WIDTH, 8: data width per channel, 1..64.
- SELW, 2: select/index width; must equal ceil(log2(NCH)).
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  NCH  per-channel data valid.
- i_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- o_ready  output  NCH  per-channel ready; at most one bit set per cycle.
- i_sel  input  SELW  external channel select (used only when MUX_RR_EN is undefined).
- o_valid  output  1  output register holds a beat.
- o_data  output  WIDTH  output beat data.
- o_chan  output  SELW  source channel of o_data.
- i_ready  input  1  consumer accepts the beat when o_valid & i_ready.

## Operation
- Load enable: ld = ~o_valid | i_ready. The output register accepts a new beat whenever it is empty or currently draining.
- Grant g is a combinational function of i_valid, i_sel and the RR pointer; gv means a grant exists.
- o_ready[g] = ld & gv. All other o_ready bits are 0. o_ready never depends on i_valid[g] of the granted channel in fixed mode.
- Transfer on channel g when i_valid[g] & o_ready[g]. On the next edge:
  - o_data <= channel g's data
  - o_chan <= g
  - o_valid <= 1
- If ld and no transfer occurs: o_valid <= 0. o_data and o_chan hold their last values.
- If ~ld (o_valid=1, i_ready=0): output register frozen; o_data and o_chan stable until accepted.
- Fixed mode: g = i_sel. If i_sel >= NCH, gv = 0 and no channel is ever accepted.
- RR mode: pointer ptr (SELW bits) holds the last granted channel.
  - The search starts at ptr+1, wraps modulo NCH, and picks the first channel with i_valid set.
  - gv = |i_valid.
  - ptr <= g only on a transfer; a stalled grant does not advance ptr.
- Simultaneous consume and load (o_valid=1, i_ready=1, transfer): the register is overwritten with the new beat. There is no bubble, so throughput is 1 beat/cycle.
- Reset (asynchronous, any time including mid-stall):
  - o_valid=0, o_data=0, o_chan=0, ptr=NCH-1, so channel 0 has first priority.
  - o_ready=0 while i_rst is high.
  - A beat held at reset is discarded.

## Timing
- Latency: input transfer at edge n gives o_valid/o_data at the output after edge n (visible in cycle n+1).
- o_ready is combinational from i_ready, o_valid, i_sel, i_valid (RR mode) and ptr. No combinational path from i_data to any output.
- Sustained throughput: 1 beat/cycle with i_ready held high.
- Backpressure: a channel's data must be held by the producer until its o_ready and i_valid coincide.
- After i_rst deasserts, the first transfer can occur at the first rising edge.

## Configuration
- MUX_RR_EN defined: round-robin arbitration among valid channels; i_sel is ignored; ptr register exists.
- MUX_RR_EN undefined: g = i_sel (registered-output fixed mux); ptr is absent; i_valid of non-selected channels is ignored.

## Test plan
- Reset mid-stall: load beat 0xA5 from ch2, hold i_ready=0, assert i_rst for 1 cycle -> o_valid=0, o_data=0, o_chan=0 immediately; no ch2 beat appears after release.
- Fixed mode, i_sel=1, i_valid=4'b1111, data ch k = 0x10+k, i_ready=1 -> o_ready=4'b0010; o_data=0x11, o_chan=1 every cycle from the cycle after the first transfer.
- Fixed mode, i_sel=1, i_valid=4'b1101 (ch1 idle), i_ready=1 -> o_ready=4'b0010; o_valid drops to 0 after the edge following loss of ch1 valid; no transfer from ch0, ch2 or ch3.
- Backpressure: o_valid=1 holding 0x33, i_ready=0 for 3 cycles -> o_ready=0, o_data=0x33 stable; on i_ready=1 a new beat loads on that same edge.
- RR mode, all 4 valid continuously, i_ready=1 -> o_chan sequence 0,1,2,3,0,1 after reset.
- RR mode, i_valid=4'b1010, ptr=1 -> grant ch3, then ch1, then ch3; i_ready=0 for 2 cycles in between -> ptr does not advance and the same channel is re-granted.
